gh_uart_rx_8bit: RTL
====================

Name: gh_uart_rx_8bit

Overview:
8-bit UART receive engine for the 16550 core. It is the receive counterpart of the existing 8-bit transmitter.
- Oversamples serial input `srx` at 16x the baud rate using the shared baud clock-enable.
- Detects and validates the start bit, then assembles 5–8 data bits LSB first.
- Checks optional parity and the stop bit.
- Presents each received word with per-word error flags to the RX FIFO as a one-cycle write pulse.

Parameters:
- SYNC_STAGES, 2, number of flops in the `srx` metastability synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- brcx16  in  1  clock enable, one pulse per 1/16 bit time
- srx  in  1  serial input; idles high; asynchronous to `clk`
- num_bits  in  int  data bits per word, 5..8
- parity_en  in  1  a parity bit follows the data
- parity_ev  in  1  1 = even parity, 0 = odd parity
- d  out  8  received word, right-justified; unused upper bits are 0
- wr  out  1  one-cycle strobe: `d` and the flags below are valid
- parity_er  out  1  parity mismatch on this word
- frame_er  out  1  stop bit sampled as 0
- break_itr  out  1  break detected: data, parity and stop all 0
- busyn  out  1  1 when the FSM is in idle

Behaviour:
- Reset:
  - `d`=0, `wr`=0, `parity_er`=0, `frame_er`=0, `break_itr`=0, `busyn`=1.
  - All synchronizer flops reset to 1; FSM goes to idle; sample counter and bit counter go to 0.
- Sampling:
  - `srx` passes through SYNC_STAGES flops; all logic below uses the synchronized value `rxs`.
  - The 4-bit sample counter `scnt` advances only on `brcx16`.
- FSM states: idle, s_start_bit, shift_data, s_parity, s_stop_bit.
- idle:
  - On a `brcx16` tick with `rxs`=0: clear `scnt`, go to s_start_bit.
- s_start_bit:
  - At `scnt`=7 (mid-bit), sample `rxs`.
  - If 1: false start; return to idle, no `wr`.
  - If 0: latch `num_bits`, `parity_en`, `parity_ev` for the whole frame; clear `scnt`, clear bit index, clear running parity; go to shift_data.
- shift_data:
  - At `scnt`=15 (next mid-bit), write the sample to `shreg[bit_idx]`, XOR it into running parity, increment `bit_idx`.
  - After bit `num_bits`−1: go to s_parity if `parity_en`, else s_stop_bit.
  - `scnt` wraps 15→0 naturally.
- s_parity:
  - At `scnt`=15, sample the parity bit; go to s_stop_bit.
  - `parity_er` = (data XOR parity bit) ≠ (`parity_ev` ? 0 : 1).
- s_stop_bit:
  - At `scnt`=15, sample the stop bit and go straight to idle. This gives a half-bit margin so the next start edge is caught back-to-back.
- Output strobe:
  - On the clock after the stop sample: `wr`=1 for exactly one `clk` cycle.
  - `d` = `shreg` with bits ≥ `num_bits` forced to 0.
  - `frame_er` = ~stop.
  - `break_itr` = (all data bits 0) & (parity bit 0 or `parity_en`=0) & (stop = 0).
  - `parity_er` = 0 when `parity_en`=0.
- Output hold:
  - `d` and the flags are registered and hold their values until the next `wr`.
  - `wr` never asserts twice for one frame.
- Latency: `wr` rises 1 `clk` after the `brcx16` tick that samples the stop bit.
- Boundary cases:
  - `num_bits` outside 5..8 is clamped to 8.
  - Config-input changes mid-frame are ignored until the next start.
  - `rst` mid-frame aborts the frame with no `wr`.
  - `srx` held low continuously: one `wr` with `break_itr`=1 and `frame_er`=1. No further `wr` until `rxs` has returned high and then fallen again (idle requires a 1→0 transition after a break).

Optional Feature:
- Macro: `GH_UART_RX_MAJORITY_VOTE_EN`.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of the samples at `scnt` = 6, 7, 8 in s_start_bit, and at `scnt` = 14, 15, 0 elsewhere. The decision is taken at the third sample, so `wr` occurs one `brcx16` tick later than without the macro.
- Undefined: a single sample at the mid-bit point, exactly as described above.

Test Plan:
- 8N1, `brcx16` every 4 clk, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1) → one `wr`; `d`=0xA5; all flags 0.
- 7E1, send 0x35 with parity bit 1 (wrong; even parity requires 0) → `d`=0x35, `parity_er`=1, `frame_er`=0. Repeat with parity bit 0 → `parity_er`=0.
- 5O1, send 0x1F with parity 0 (correct for odd) → `d`=0x1F, upper bits 0, `parity_er`=0.
- 8N1, 0.4-bit-wide low glitch on `srx` → no `wr`; `busyn` returns to 1 within one bit time.
- Hold `srx` low for 3 frame times, then release → exactly one `wr` with `d`=0x00, `break_itr`=1, `frame_er`=1. A following valid 0x55 frame gives `d`=0x55 with clean flags.
- Two back-to-back 8N1 frames 0x01, 0xFF with no idle gap → two `wr` pulses 160 `brcx16` ticks apart. Assert `rst` mid-way through the third frame → no `wr`, and all outputs return to reset values.

Source files
------------

// File: rtl/gh_uart_rx_8bit.sv
`default_nettype none
// ============================================================================
// Module   : gh_uart_rx_8bit
// Purpose  : 8-bit UART receive engine for the 16550 core. Oversamples srx at
//            16x baud, validates the start bit, shifts in 5..8 data bits LSB
//            first, checks optional parity and the stop bit, and presents each
//            word with error flags as a one-cycle write strobe.
// Options  : GH_UART_RX_MAJORITY_VOTE_EN - 2-of-3 majority vote per bit.
// Revision : 1.0 - initial release
// ============================================================================
module gh_uart_rx_8bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brcx16,
    input  logic       srx,
    input  int         num_bits,
    input  logic       parity_en,
    input  logic       parity_ev,
    output logic [7:0] d,
    output logic       wr,
    output logic       parity_er,
    output logic       frame_er,
    output logic       break_itr,
    output logic       busyn
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

`ifdef GH_UART_RX_MAJORITY_VOTE_EN
    // Decision at the third vote sample; restarting at 1 keeps the next
    // decision point (scnt=0) exactly one bit time away.
    localparam logic [3:0] C_START_PT = 4'd8;
    localparam logic [3:0] C_DATA_PT  = 4'd0;
    localparam logic [3:0] C_RESTART  = 4'd1;
`else
    localparam logic [3:0] C_START_PT = 4'd7;
    localparam logic [3:0] C_DATA_PT  = 4'd15;
    localparam logic [3:0] C_RESTART  = 4'd0;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [3:0]             r_scnt;
    logic [2:0]             r_bidx;
    logic [7:0]             r_shreg;
    logic [3:0]             r_nb;
    logic                   r_pen;
    logic                   r_pev;
    logic                   r_par;
    logic                   r_parbit;
    logic                   r_stop;
    logic                   r_brk_pend;
    logic                   r_fin;
    logic                   r_wait_high;
    logic [7:0]             r_d;
    logic                   r_wr;
    logic                   r_per;
    logic                   r_fer;
    logic                   r_brk;

    logic                   w_rxs;
    logic [3:0]             w_nb_clamp;
    logic [7:0]             w_mask;
    logic [7:0]             w_data;
    logic                   w_pt;
    logic                   w_bit;
    logic                   w_last;
    logic                   w_break;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_nb_clamp = (num_bits >= 5 && num_bits <= 8) ? num_bits[3:0] : 4'd8;
    assign w_mask     = 8'hFF >> (4'd8 - r_nb);
    assign w_data     = r_shreg & w_mask;
    assign w_pt       = (r_state == ST_START) ? (r_scnt == C_START_PT)
                                              : (r_scnt == C_DATA_PT);
    assign w_last     = ({1'b0, r_bidx} == (r_nb - 4'd1));
    assign w_break    = (w_data == 8'h00) & (~r_pen | ~r_parbit) & ~w_bit;

    // Metastability synchronizer for the asynchronous serial input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], srx};
    end

`ifdef GH_UART_RX_MAJORITY_VOTE_EN
    logic r_v0;
    logic r_v1;

    // Capture the two samples preceding the decision point for the vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else if (brcx16) begin
            if (r_scnt == ((r_state == ST_START) ? 4'd6 : 4'd14)) r_v0 <= w_rxs;
            if (r_scnt == ((r_state == ST_START) ? 4'd7 : 4'd15)) r_v1 <= w_rxs;
        end
    end

    assign w_bit = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    // Receive FSM: start validation, data shift, parity and stop sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scnt      <= 4'd0;
            r_bidx      <= 3'd0;
            r_shreg     <= 8'h00;
            r_nb        <= 4'd8;
            r_pen       <= 1'b0;
            r_pev       <= 1'b0;
            r_par       <= 1'b0;
            r_parbit    <= 1'b0;
            r_stop      <= 1'b1;
            r_brk_pend  <= 1'b0;
            r_fin       <= 1'b0;
            r_wait_high <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            // After a break the line must go high before a new start is accepted
            if (r_state == ST_IDLE && w_rxs) r_wait_high <= 1'b0;
            if (brcx16) begin
                r_scnt <= r_scnt + 4'd1;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rxs && !r_wait_high) begin
                            r_scnt  <= 4'd0;
                            r_state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (w_pt) begin
                            if (w_bit) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_nb     <= w_nb_clamp;
                                r_pen    <= parity_en;
                                r_pev    <= parity_ev;
                                r_scnt   <= C_RESTART;
                                r_bidx   <= 3'd0;
                                r_par    <= 1'b0;
                                r_parbit <= 1'b0;
                                r_shreg  <= 8'h00;
                                r_state  <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_pt) begin
                            r_shreg[r_bidx] <= w_bit;
                            r_par           <= r_par ^ w_bit;
                            r_bidx          <= r_bidx + 3'd1;
                            if (w_last) r_state <= r_pen ? ST_PAR : ST_STOP;
                        end
                    end
                    ST_PAR: begin
                        if (w_pt) begin
                            r_parbit <= w_bit;
                            r_state  <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (w_pt) begin
                            r_stop     <= w_bit;
                            r_brk_pend <= w_break;
                            r_fin      <= 1'b1;
                            r_state    <= ST_IDLE;
                            if (w_break) r_wait_high <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Output register: one-cycle strobe, word and flags held until next strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= 1'b0;
            r_d   <= 8'h00;
            r_per <= 1'b0;
            r_fer <= 1'b0;
            r_brk <= 1'b0;
        end else begin
            r_wr <= r_fin;
            if (r_fin) begin
                r_d   <= w_data;
                r_fer <= ~r_stop;
                r_brk <= r_brk_pend;
                r_per <= r_pen & ((r_par ^ r_parbit) != ~r_pev);
            end
        end
    end

    assign d         = r_d;
    assign wr        = r_wr;
    assign parity_er = r_per;
    assign frame_er  = r_fer;
    assign break_itr = r_brk;
    assign busyn     = (r_state == ST_IDLE);

endmodule
`default_nettype wire
